// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU datapath types.
//   word_t          : 32-bit machine word.
//   icachef_t       : instruction address split {tag, idx, bytoff} for a
//                     16-frame direct-mapped icache (26/4/2 bits).
//   icache_frame_t  : one icache frame {valid, tag, data}.
//   icache_state_t  : icache fill controller states {IDLE, FETCH}.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int ICACHE_SETS  = 16;
   localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
   localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

   typedef struct packed {
      logic [ICACHE_TAG_W-1:0] tag;
      logic [ICACHE_IDX_W-1:0] idx;
      logic [1:0]              bytoff;
   } icachef_t;

   typedef struct packed {
      logic                    valid;
      logic [ICACHE_TAG_W-1:0] tag;
      word_t                   data;
   } icache_frame_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
//   Direct-mapped, read-only instruction cache. Answers datapath fetches with
//   a zero-latency hit path and fills one word per miss from the memory
//   controller.
//
//   Parameters
//     SETS      number of frames (power of two, >= 2)
//
//   Ports
//     CLK       in   clock, rising edge
//     RST       in   synchronous active-high reset
//     imemREN   in   fetch request
//     imemaddr  in   fetch byte address (bits [1:0] ignored)
//     ihit      out  requested word valid this cycle
//     imemload  out  instruction word, 0 when ihit=0
//     iREN      out  memory read request (FETCH only)
//     iaddr     out  memory word address of the pending fill
//     iwait     in   memory busy; fill completes when iREN=1 and iwait=0
//     iload     in   memory read data, valid when iwait=0
// -----------------------------------------------------------------------------
module icache
   import cpu_types_pkg::*;
#(
   parameter int SETS = 16
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  imemREN,
   input  word_t imemaddr,
   output logic  ihit,
   output word_t imemload,
   output logic  iREN,
   output word_t iaddr,
   input  logic  iwait,
   input  word_t iload
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   icache_state_t    r_state;
   icache_state_t    w_next_state;
   word_t            r_miss_addr;
   logic [SETS-1:0]  r_valid;
   logic [TAG_W-1:0] r_tag  [SETS];
   word_t            r_data [SETS];

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_fill_idx;
   logic [TAG_W-1:0] w_fill_tag;
   logic             w_tag_match;
   logic             w_miss;
   logic             w_fill;

   // Lookup side decodes the live fetch address; fill side decodes the
   // latched miss address so a redirect during FETCH cannot move the fill.
   assign w_idx      = imemaddr[IDX_W+1:2];
   assign w_tag      = imemaddr[31:IDX_W+2];
   assign w_fill_idx = r_miss_addr[IDX_W+1:2];
   assign w_fill_tag = r_miss_addr[31:IDX_W+2];

   assign w_tag_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_fill      = (r_state == FETCH) && !iwait;

   // NOTE: every state register uses non-blocking assignments so all
   // flops sample the pre-edge values regardless of block ordering.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid     <= '0;
         r_miss_addr <= '0;
      end else begin
         if (w_miss) begin
            r_miss_addr <= imemaddr & 32'hFFFF_FFFC;
         end
         if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
         end
      end
   end

   // NOTE: tag/data storage has no reset; a frame is only observable once its
   // valid bit is set, so clearing valid is enough and keeps this a plain RAM.
   // A fill in flight when RST arrives is dropped here as well.
   always_ff @(posedge CLK) begin
      if (!RST && w_fill) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= iload;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_miss       = 1'b0;
      ihit         = 1'b0;
      imemload     = '0;
      iREN         = 1'b0;
      iaddr        = '0;
      case (r_state)
         IDLE: begin
            if (imemREN) begin
               if (w_tag_match) begin
                  ihit     = 1'b1;
                  imemload = r_data[w_idx];
               end else begin
                  w_miss       = 1'b1;
                  w_next_state = FETCH;
               end
            end
         end
         FETCH: begin
            // The fill always runs to completion; imemREN/imemaddr are not
            // looked at until the return to IDLE.
            iREN  = 1'b1;
            iaddr = r_miss_addr;
            if (!iwait) begin
               w_next_state = IDLE;
            end
         end
      endcase
   end

endmodule
